// File: rtl/shiftreg_fifo_mc_if.sv
// Handshake bundle for the multi-channel shift-register FIFO.
// Channel c occupies slice [c*W +: W] of every packed bus.
interface shiftreg_fifo_mc_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_CH     = 2
);
    logic [NUM_CH-1:0]                  if_write;
    logic [NUM_CH*DATA_WIDTH-1:0]       if_din;
    logic [NUM_CH-1:0]                  if_full_n;
    logic [NUM_CH-1:0]                  if_read;
    logic [NUM_CH*DATA_WIDTH-1:0]       if_dout;
    logic [NUM_CH-1:0]                  if_empty_n;
    logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   if_num_data_valid;
    logic [NUM_CH-1:0]                  if_almost_full;
    logic [NUM_CH-1:0]                  flush;

    // Producer/consumer side
    modport master (
        output if_write, if_din, if_read, flush,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_almost_full
    );

    // FIFO side
    modport slave (
        input  if_write, if_din, if_read, flush,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_almost_full
    );
endinterface

// File: rtl/shiftreg_fifo_mc.sv
// Multi-channel first-word-fall-through FIFO. Each channel is a shift-on-write
// store (no reset, so it maps onto SRLs) read at address cnt-1, with registered
// full/empty/almost-full flags derived from the next occupancy.
module shiftreg_fifo_mc #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 2,
    parameter int AF_THRESH  = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    shiftreg_fifo_mc_if.slave    bus
);
    localparam int CW = ADDR_WIDTH + 1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] store [DEPTH];
        logic [CW-1:0]         cnt;
        logic [CW-1:0]         cnt_nxt;
        logic                  full_n_q;
        logic                  empty_n_q;
        logic                  af_q;
        logic                  push;
        logic                  pop;
        logic [ADDR_WIDTH-1:0] rd_addr;

        // Flush wins, so a flushed push must not shift the store either.
        assign push = bus.if_write[c] & full_n_q & ~bus.flush[c];
        assign pop  = bus.if_read[c]  & empty_n_q;

        // Occupancy update; simultaneous push and pop holds the count.
        always_comb begin
            cnt_nxt = cnt;
            if (bus.flush[c])
                cnt_nxt = '0;
            else if (push && !pop)
                cnt_nxt = cnt + CW'(1);
            else if (pop && !push)
                cnt_nxt = cnt - CW'(1);
        end

        // Shift-on-write store; deliberately unreset so it infers SRL.
        always_ff @(posedge clk) begin
            if (push) begin
                store[0] <= bus.if_din[c*DATA_WIDTH +: DATA_WIDTH];
                for (int i = 1; i < DEPTH; i++)
                    store[i] <= store[i-1];
            end
        end

        // Count and flags registered from the next occupancy.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt       <= '0;
                full_n_q  <= 1'b1;
                empty_n_q <= 1'b0;
                af_q      <= 1'b0;
            end else begin
                cnt       <= cnt_nxt;
                full_n_q  <= (cnt_nxt != CW'(DEPTH));
                empty_n_q <= (cnt_nxt != '0);
                af_q      <= (cnt_nxt >= CW'(AF_THRESH));
            end
        end

        // Head sits at cnt-1; only meaningful while non-empty.
        assign rd_addr = ADDR_WIDTH'(cnt - CW'(1));

        assign bus.if_dout[c*DATA_WIDTH +: DATA_WIDTH] = empty_n_q ? store[rd_addr] : '0;
        assign bus.if_full_n[c]                        = full_n_q;
        assign bus.if_empty_n[c]                       = empty_n_q;
        assign bus.if_almost_full[c]                   = af_q;
        assign bus.if_num_data_valid[c*CW +: CW]       = cnt;
    end
endmodule

// File: doc/shiftreg_fifo_mc.md
# shiftreg_fifo_mc

Multi-channel, parametrised first-word-fall-through FIFO built on an addressed shift-register store, one per channel. It is the next-generation replacement for the single-channel start/stream shift registers between dataflow tasks in the Linear_Layer kernels. It adds per-channel full/empty handshakes, occupancy counters, an almost-full flag and a synchronous per-channel flush. NUM_CH independent channels share one clock and reset; there is no interaction between channels.

## Interface
Parameters:
- DATA_WIDTH, 8, payload bits per entry (>=1)
- ADDR_WIDTH, 4, store address bits; DEPTH <= 2**ADDR_WIDTH
- DEPTH, 16, entries per channel (>=2)
- NUM_CH, 2, number of independent channels (>=1)
- AF_THRESH, 14, almost-full asserts when occupancy >= AF_THRESH (1..DEPTH)

Ports (channel c occupies slice [c*W +: W] of packed buses):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- if_write  in  NUM_CH  push request per channel
- if_din  in  NUM_CH*DATA_WIDTH  push data
- if_full_n  out  NUM_CH  1 = channel can accept a push
- if_read  in  NUM_CH  pop request per channel
- if_dout  out  NUM_CH*DATA_WIDTH  head-of-queue data (fall-through)
- if_empty_n  out  NUM_CH  1 = if_dout holds valid data
- if_num_data_valid  out  NUM_CH*(ADDR_WIDTH+1)  current occupancy
- if_almost_full  out  NUM_CH  occupancy >= AF_THRESH
- flush  in  NUM_CH  synchronous clear of channel occupancy

## Operation
- Per channel: store of DEPTH entries, shift-on-write. An accepted push shifts every entry up one slot and writes if_din into slot 0. The store has no reset, so it infers SRL.
- Counter cnt (0..DEPTH). Read address = cnt-1. if_dout = store[cnt-1] when if_empty_n=1, else all zeros (gated mux).
- push = if_write & if_full_n; pop = if_read & if_empty_n. Requests while the flag is low are ignored with no side effect.
- Next count:
  - flush: 0
  - push & !pop: cnt+1
  - pop & !push: cnt-1
  - otherwise: cnt
- Simultaneous push and pop on a non-empty, non-full channel: the store shifts and cnt is held. The new head is the old store[cnt-2] after the shift. FIFO order is preserved.
- Empty channel: pop is ignored and push is accepted. There is no same-cycle bypass.
- Full channel: push is ignored even if a pop occurs in the same cycle, because if_full_n is a registered flag.
- Flush has priority over push and pop in the same cycle. Store contents are left stale but are unreachable.
- Flags are registered from the next count:
  - if_full_n = (next != DEPTH)
  - if_empty_n = (next != 0)
  - if_almost_full = (next >= AF_THRESH)
  - if_num_data_valid = cnt
- Reset (asynchronous, any time including mid-transfer) sets, per channel: cnt=0, if_empty_n=0, if_full_n=1, if_almost_full=0, if_dout=0, if_num_data_valid=0. All queued data is lost. Deassertion is assumed synchronised upstream.

## Timing
- Write-to-read latency is 1 cycle. A push accepted at edge N gives if_empty_n=1 and valid if_dout from edge N until consumed.
- A pop accepted at edge N presents the next entry (or empty_n=0) right after edge N.
- if_full_n drops at the edge that accepts the DEPTH-th entry. It rises at the edge of the first pop from full.
- if_dout is combinational from the registered cnt and the store. There is no input-to-output combinational path from if_read or if_write.
- Throughput is 1 push and 1 pop per cycle per channel, sustained at any occupancy 1..DEPTH-1.

## Test plan
- Reset then idle, DEPTH=16:
  - All channels: full_n=1, empty_n=0, dout=0, num_data_valid=0, almost_full=0.
  - Reset asserted mid-stream returns to this state immediately, without waiting for a clock edge.
- Ch0 fill with 0x01..0x10:
  - almost_full rises after the 14th push.
  - full_n=0 after the 16th push; a 17th write of 0xFF is dropped.
  - Draining yields 0x01..0x10 in order; empty_n=0 after the 16th pop.
- Ch1 at occupancy 5, push+pop every cycle for 20 cycles:
  - num_data_valid stays 5.
  - The output sequence matches the input sequence delayed by 5 entries.
  - Ch0 is untouched throughout.
- Read while empty and write in the same cycle (0xA5):
  - The read is ignored.
  - Next cycle: empty_n=1, dout=0xA5, count=1.
- Full channel, write+read in the same cycle:
  - Only the pop is taken; count=15 and full_n=1 next cycle.
  - The written word does not appear in the drained output.
- Ch0 at count 7, flush with write+read asserted:
  - Next cycle: count=0, empty_n=0, dout=0.
  - Ch1 count is unchanged.
  - A subsequent push of 0x3C is read back as 0x3C.
